// File: rtl/bioz_siggen_pkg.sv
// Shared types and default widths for the BioZ signal-generator RAM controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bioz_siggen_pkg;

   localparam int DEFAULT_DATA_WIDTH = 12;
   localparam int DEFAULT_ADDR_WIDTH = 8;
   localparam int DEFAULT_DIV_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      RD_ISSUE = 2'd2,
      RD_CAP   = 2'd3
   } state_t;

endpackage

// File: rtl/bioz_siggen_ram_ctrl_if.sv
// Host load and playback control/status bundle for the waveform RAM controller.
// Latency: n/a (wiring only).
// Backpressure: host writes are held off by wr_ready; playback outputs cannot be stalled.
interface bioz_siggen_ram_ctrl_if #(
   parameter int DATA_WIDTH = bioz_siggen_pkg::DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = bioz_siggen_pkg::DEFAULT_ADDR_WIDTH,
   parameter int DIV_WIDTH  = bioz_siggen_pkg::DEFAULT_DIV_WIDTH
);
   logic                  enable;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic [DIV_WIDTH-1:0]  rate_div;
   logic                  wr_valid;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] sample;
   logic                  sample_valid;
   logic                  wrap;
   logic                  overrun;

   modport master (
      output enable, last_addr, rate_div, wr_valid, wr_addr, wr_data,
      input  wr_ready, sample, sample_valid, wrap, overrun
   );

   modport slave (
      input  enable, last_addr, rate_div, wr_valid, wr_addr, wr_data,
      output wr_ready, sample, sample_valid, wrap, overrun
   );
endinterface

// File: rtl/bioz_siggen_rate_div.sv
// Playback tick generator: one tick every rate_div+1 cycles while enabled.
// Latency: first tick combinationally in the first cycle enable is high.
// Backpressure: none; ticks are free-running and may be dropped downstream.
module bioz_siggen_rate_div
   import bioz_siggen_pkg::*;
#(
   parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] rate_div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] div_cnt;

   // Count 0..rate_div; >= lets a shrunk rate_div restart cleanly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (!enable || (div_cnt >= rate_div)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = enable && (div_cnt == '0);

endmodule

// File: rtl/bioz_siggen_ram_ctrl.sv
// Shares one single-port waveform RAM between host writes and cyclic playback reads.
// Latency: tick in T -> RD_ISSUE T+1, RD_CAP T+2, sample_valid T+3; a write occupies 1 cycle.
// Backpressure: wr_ready low while a read is pending or in progress; late ticks set overrun.
module bioz_siggen_ram_ctrl
   import bioz_siggen_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bioz_siggen_ram_ctrl_if.slave ctrl,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);

   state_t                state, state_nxt;
   logic                  rd_pend, alive, wrap_q;
   logic                  sample_valid_q, wrap_out_q, overrun_q;
   logic [DATA_WIDTH-1:0] sample_q, wdata_q;
   logic [ADDR_WIDTH-1:0] rd_ptr, addr_q;
   logic                  tick, busy, take_tick, wr_ready_int, wr_fire, go_rd;

   bioz_siggen_rate_div #(.DIV_WIDTH(DIV_WIDTH)) u_rate_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (ctrl.enable),
      .rate_div (ctrl.rate_div),
      .tick     (tick)
   );

   // A tick can only be accepted when no read is pending or running.
   assign busy         = rd_pend || (state == RD_ISSUE) || (state == RD_CAP);
   assign take_tick    = tick && !busy;
   assign wr_ready_int = alive && (state == IDLE) && !rd_pend;
   assign wr_fire      = ctrl.wr_valid && wr_ready_int;
   // A fresh tick goes straight to RD_ISSUE unless a write handshake claims this cycle.
   assign go_rd        = (state == IDLE) && ctrl.enable && (rd_pend || (take_tick && !wr_fire));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and RAM control decode.
   always_comb begin
      state_nxt = state;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
      case (state)
         IDLE: begin
            if (go_rd)        state_nxt = RD_ISSUE;
            else if (wr_fire) state_nxt = WRITE;
         end
         WRITE: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            state_nxt = IDLE;
         end
         RD_ISSUE: begin
            ram_cs    = 1'b1;
            ram_oe    = 1'b1;
            state_nxt = RD_CAP;
         end
         RD_CAP: begin
            ram_cs    = 1'b1;
            ram_oe    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pending-read flag and sticky overrun; both cleared whenever playback is off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend   <= 1'b0;
         overrun_q <= 1'b0;
      end else if (!ctrl.enable) begin
         rd_pend   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (go_rd)          rd_pend <= 1'b0;
         else if (take_tick) rd_pend <= 1'b1;
         if (tick && busy)   overrun_q <= 1'b1;
      end
   end

   // Address/data latches and read pointer; pointer wraps on >= so a shrunk last_addr is safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rd_ptr  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         if (state_nxt == WRITE) begin
            addr_q  <= ctrl.wr_addr;
            wdata_q <= ctrl.wr_data;
         end else if (state_nxt == RD_ISSUE) begin
            addr_q  <= rd_ptr;
         end
         if (state == RD_ISSUE) wrap_q <= (rd_ptr >= ctrl.last_addr);
         if (!ctrl.enable)
            rd_ptr <= '0;
         else if (state == RD_ISSUE)
            rd_ptr <= (rd_ptr >= ctrl.last_addr) ? '0 : rd_ptr + 1'b1;
      end
   end

   // Sample capture at the end of RD_CAP; alive holds wr_ready low until reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive          <= 1'b0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         wrap_out_q     <= 1'b0;
      end else begin
         alive          <= 1'b1;
         sample_valid_q <= (state == RD_CAP);
         wrap_out_q     <= (state == RD_CAP) && wrap_q;
         if (state == RD_CAP) sample_q <= ram_data;
      end
   end

   assign ram_address       = addr_q;
   assign ram_data          = (state == WRITE) ? wdata_q : {DATA_WIDTH{1'bz}};
   assign ctrl.wr_ready     = wr_ready_int;
   assign ctrl.sample       = sample_q;
   assign ctrl.sample_valid = sample_valid_q;
   assign ctrl.wrap         = wrap_out_q;
   assign ctrl.overrun      = overrun_q;

endmodule

// File: tb/tb_bioz_siggen_ram_ctrl.sv
// Bench for bioz_siggen_ram_ctrl with a synchronous RAM model on the shared bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_bioz_siggen_ram_ctrl;
   localparam int DW = 12;
   localparam int AW = 8;
   localparam int VW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] ram_address;
   logic          ram_cs, ram_we, ram_oe;
   wire  [DW-1:0] ram_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   bioz_siggen_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(VW)) bus ();

   bioz_siggen_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_WIDTH(VW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ctrl        (bus),
      .ram_address (ram_address),
      .ram_cs      (ram_cs),
      .ram_we      (ram_we),
      .ram_oe      (ram_oe),
      .ram_data    (ram_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM: registers read data on a read cycle, drives the bus while cs&oe&!we.
   logic [DW-1:0] ram_mem [0:255];
   logic [DW-1:0] ram_q;
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};
   always @(posedge clk) begin
      if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
      if (ram_cs && ram_oe && !ram_we) ram_q <= ram_mem[ram_address];
   end

   // Reference contents as the host believes them to be.
   logic [DW-1:0] ref_mem [0:255];

   typedef struct { int c; logic [DW-1:0] d; logic w; } ev_t;
   ev_t evq[$];

   always @(negedge clk) begin
      if (bus.sample_valid) evq.push_back('{c: cyc, d: bus.sample, w: bus.wrap});
   end

   // Controller write and RAM read drive must never coexist.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && ram_cs) begin
         n_checks++;
         if (ram_we && ram_oe) begin
            n_fail++;
            $display("FAIL bus_contention cyc=%0d: we=%b oe=%b, required not both high", cyc, ram_we, ram_oe);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit done = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.wr_ready) done = 1'b1;
         step(1);
      end
      bus.wr_valid = 1'b0;
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL write_accept addr=%0d: wr_ready stayed 0 for 20 cycles, required 1", a);
      end else begin
         ref_mem[a] = d;
      end
      step(1);
   endtask

   task automatic stop_play();
      bus.enable = 1'b0;
      step(6);
      evq.delete();
   endtask

   task automatic test_reset();
      bus.enable = 0; bus.last_addr = 0; bus.rate_div = 0;
      bus.wr_valid = 0; bus.wr_addr = 0; bus.wr_data = 0;
      rst_n = 1'b0;
      step(2);
      n_checks++;
      if ({bus.sample, bus.sample_valid, bus.wrap, bus.overrun, bus.wr_ready} !== {12'h000, 4'b0000}) begin
         n_fail++;
         $display("FAIL reset_outputs: sample=%h sv=%b wrap=%b ovr=%b rdy=%b, required all 0",
                  bus.sample, bus.sample_valid, bus.wrap, bus.overrun, bus.wr_ready);
      end
      n_checks++;
      if ({ram_cs, ram_we, ram_oe, ram_address} !== 11'h0) begin
         n_fail++;
         $display("FAIL reset_ram_pins: cs=%b we=%b oe=%b addr=%h, required all 0", ram_cs, ram_we, ram_oe, ram_address);
      end
      rst_n = 1'b1;
      step(1);
      n_checks++;
      if (bus.wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: wr_ready=%b, required 1", bus.wr_ready);
      end
      // Start a write, then abort it asynchronously in its WRITE cycle.
      bus.wr_valid = 1'b1; bus.wr_addr = 8'd5; bus.wr_data = 12'hABC;
      step(1);
      bus.wr_valid = 1'b0;
      n_checks++;
      if ({ram_cs, ram_we, ram_oe, ram_address} !== {3'b110, 8'd5}) begin
         n_fail++;
         $display("FAIL write_cycle: cs=%b we=%b oe=%b addr=%0d, required 1 1 0 5", ram_cs, ram_we, ram_oe, ram_address);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ram_cs, ram_we, ram_oe, ram_address, bus.wr_ready} !== 12'h0) begin
         n_fail++;
         $display("FAIL reset_async_abort: cs=%b we=%b oe=%b addr=%h rdy=%b, required all 0",
                  ram_cs, ram_we, ram_oe, ram_address, bus.wr_ready);
      end
      step(1);
      rst_n = 1'b1;
      step(1);
      n_checks++;
      if (bus.wr_ready !== 1'b1 || evq.size() != 0) begin
         n_fail++;
         $display("FAIL reset_after_abort: wr_ready=%b samples=%0d, required 1 and 0", bus.wr_ready, evq.size());
      end
   endtask

   task automatic test_load_play();
      int c;
      host_write(8'd0, 12'h111);
      host_write(8'd1, 12'h222);
      host_write(8'd2, 12'h333);
      host_write(8'd3, 12'h444);
      bus.last_addr = 8'd3; bus.rate_div = 16'd3;
      evq.delete();
      c = cyc;
      bus.enable = 1'b1;
      step(20);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (k >= evq.size()) begin
            n_fail++;
            $display("FAIL load_play_count k=%0d: got %0d samples, required 5", k, evq.size());
         end else if (evq[k].c != c + 3 + 4 * k || evq[k].d !== ref_mem[k % 4] || evq[k].w !== (k % 4 == 3)) begin
            n_fail++;
            $display("FAIL load_play k=%0d: got cyc=%0d data=%h wrap=%b, required cyc=%0d data=%h wrap=%b",
                     k, evq[k].c - c, evq[k].d, evq[k].w, 3 + 4 * k, ref_mem[k % 4], (k % 4 == 3));
         end
      end
      stop_play();
   endtask

   task automatic test_collision();
      int c;
      logic [DW-1:0] d;
      d = DW'($urandom_range(1, 4095));
      bus.last_addr = 8'd3; bus.rate_div = 16'd4;
      evq.delete();
      c = cyc;
      bus.enable = 1'b1;
      step(1);
      bus.wr_valid = 1'b1; bus.wr_addr = 8'd200; bus.wr_data = d;
      n_checks++;
      if (bus.wr_ready !== 1'b0) begin
         n_fail++; $display("FAIL collision_ready_issue: wr_ready=%b, required 0", bus.wr_ready);
      end
      step(1);
      n_checks++;
      if (bus.wr_ready !== 1'b0 || ram_oe !== 1'b1) begin
         n_fail++; $display("FAIL collision_ready_cap: wr_ready=%b oe=%b, required 0 1", bus.wr_ready, ram_oe);
      end
      step(1);
      n_checks++;
      if (bus.wr_ready !== 1'b1) begin
         n_fail++; $display("FAIL collision_ready_after: wr_ready=%b, required 1", bus.wr_ready);
      end
      step(1);
      n_checks++;
      if ({ram_we, ram_oe, ram_address} !== {2'b10, 8'd200} || ram_data !== d) begin
         n_fail++;
         $display("FAIL collision_write: we=%b oe=%b addr=%0d data=%h, required 1 0 200 %h", ram_we, ram_oe, ram_address, ram_data, d);
      end
      bus.wr_valid = 1'b0;
      ref_mem[200] = d;
      step(9);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (k >= evq.size()) begin
            n_fail++;
            $display("FAIL collision_count k=%0d: got %0d samples, required 3", k, evq.size());
         end else if (evq[k].c != c + 3 + 5 * k || evq[k].d !== ref_mem[k]) begin
            n_fail++;
            $display("FAIL collision_cadence k=%0d: got cyc=%0d data=%h, required cyc=%0d data=%h",
                     k, evq[k].c - c, evq[k].d, 3 + 5 * k, ref_mem[k]);
         end
      end
      n_checks++;
      if (ram_mem[200] !== d) begin
         n_fail++; $display("FAIL collision_ram_content: got %h, required %h", ram_mem[200], d);
      end
      stop_play();
   endtask

   task automatic test_overrun();
      int c;
      bus.last_addr = 8'd3; bus.rate_div = 16'd0;
      evq.delete();
      c = cyc;
      bus.enable = 1'b1;
      step(1);
      n_checks++;
      if (bus.overrun !== 1'b0) begin
         n_fail++; $display("FAIL overrun_first_tick: overrun=%b, required 0", bus.overrun);
      end
      step(1);
      n_checks++;
      if (bus.overrun !== 1'b1) begin
         n_fail++; $display("FAIL overrun_second_tick: overrun=%b, required 1", bus.overrun);
      end
      step(8);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (k >= evq.size()) begin
            n_fail++;
            $display("FAIL overrun_count k=%0d: got %0d samples, required 3", k, evq.size());
         end else if (evq[k].c != c + 3 + 3 * k || evq[k].d !== ref_mem[k]) begin
            n_fail++;
            $display("FAIL overrun_cadence k=%0d: got cyc=%0d data=%h, required cyc=%0d data=%h",
                     k, evq[k].c - c, evq[k].d, 3 + 3 * k, ref_mem[k]);
         end
      end
      bus.enable = 1'b0;
      step(1);
      n_checks++;
      if (bus.overrun !== 1'b0) begin
         n_fail++; $display("FAIL overrun_clear: overrun=%b, required 0", bus.overrun);
      end
      stop_play();
   endtask

   task automatic test_enable_drop();
      int c;
      bus.last_addr = 8'd3; bus.rate_div = 16'd3;
      evq.delete();
      c = cyc;
      bus.enable = 1'b1;
      step(10);
      n_checks++;
      if ({ram_oe, ram_we} !== 2'b10) begin
         n_fail++; $display("FAIL drop_in_read: oe=%b we=%b, required 1 0", ram_oe, ram_we);
      end
      bus.enable = 1'b0;
      step(12);
      n_checks++;
      if (evq.size() != 3 || evq[2].c != c + 11 || evq[2].d !== ref_mem[2]) begin
         n_fail++;
         $display("FAIL drop_completes: got %0d samples, last data=%h, required 3 samples ending with %h at cyc %0d",
                  evq.size(), (evq.size() > 0) ? evq[evq.size()-1].d : 12'h0, ref_mem[2], 11);
      end
      evq.delete();
      c = cyc;
      bus.enable = 1'b1;
      step(3);
      n_checks++;
      if (evq.size() != 1 || evq[0].c != c + 3 || evq[0].d !== ref_mem[0]) begin
         n_fail++;
         $display("FAIL reenable_addr0: got %0d samples, first data=%h, required 1 sample %h at cyc 3",
                  evq.size(), (evq.size() > 0) ? evq[0].d : 12'h0, ref_mem[0]);
      end
      stop_play();
   endtask

   task automatic test_shrink();
      int c;
      int exp_addr[9] = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
      for (int a = 0; a < 10; a++) host_write(AW'(a), DW'($urandom_range(0, 4095)));
      bus.last_addr = 8'd9; bus.rate_div = 16'd3;
      evq.delete();
      c = cyc;
      bus.enable = 1'b1;
      step(22);
      bus.last_addr = 8'd4;
      step(14);
      for (int k = 0; k < 9; k++) begin
         n_checks++;
         if (k >= evq.size()) begin
            n_fail++;
            $display("FAIL shrink_count k=%0d: got %0d samples, required 9", k, evq.size());
         end else if (evq[k].d !== ref_mem[exp_addr[k]] || evq[k].w !== (k == 6) || evq[k].c != c + 3 + 4 * k) begin
            n_fail++;
            $display("FAIL shrink k=%0d: got cyc=%0d data=%h wrap=%b, required cyc=%0d data=%h wrap=%b",
                     k, evq[k].c - c, evq[k].d, evq[k].w, 3 + 4 * k, ref_mem[exp_addr[k]], (k == 6));
         end
      end
      stop_play();
   endtask

   task automatic test_random_play();
      int c, last, rd, n;
      repeat (3) begin
         last = $urandom_range(1, 12);
         rd   = $urandom_range(2, 5);
         n    = $urandom_range(3, 8) + last;
         for (int a = 0; a <= last; a++) host_write(AW'(a), DW'($urandom_range(0, 4095)));
         bus.last_addr = AW'(last); bus.rate_div = VW'(rd);
         evq.delete();
         c = cyc;
         bus.enable = 1'b1;
         step(3 + (n - 1) * (rd + 1) + 1);
         for (int k = 0; k < n; k++) begin
            n_checks++;
            if (k >= evq.size()) begin
               n_fail++;
               $display("FAIL random_count k=%0d: got %0d samples, required %0d", k, evq.size(), n);
            end else if (evq[k].c != c + 3 + k * (rd + 1) || evq[k].d !== ref_mem[k % (last + 1)] ||
                         evq[k].w !== (k % (last + 1) == last)) begin
               n_fail++;
               $display("FAIL random_play k=%0d last=%0d div=%0d: got cyc=%0d data=%h wrap=%b, required cyc=%0d data=%h wrap=%b",
                        k, last, rd, evq[k].c - c, evq[k].d, evq[k].w, 3 + k * (rd + 1),
                        ref_mem[k % (last + 1)], (k % (last + 1) == last));
            end
         end
         stop_play();
      end
   endtask

   initial begin
      test_reset();
      test_load_play();
      test_collision();
      test_overrun();
      test_enable_drop();
      test_shrink();
      test_random_play();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "watchdog expired");
   end

endmodule
